demux_1x2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer: the inverse of the team's 2:1 byte mux.
- Accepts one data word per valid/ready handshake on a single input. Routes it by a per-word select bit to one of two output channels.
- Each output channel has its own 2-entry FIFO, so a stalled consumer does not block the other channel.
- Sits between a shared producer and two independent consumers in the lab datapath.

---
 rtl/demux_1x2_stream.sv | 97 +++++++++
 tb/tb_demux_1x2_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
// Define DEMUX_STATS_EN to build the per-channel delivered-word counters cnt0/cnt1.
module demux_1x2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    logic [WIDTH-1:0] mem [2][2];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       count [2];
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;

    assign out_ready = {out1_ready, out0_ready};

    // Readiness depends only on the addressed channel, so one stalled
    // consumer never blocks words headed for the other channel.
    assign in_ready = !full[in_sel];

    always_comb begin
        full = '0;
        push = '0;
        pop  = '0;
        for (int c = 0; c < 2; c++) begin
            full[c] = (count[c] == 2'(DEPTH));
            push[c] = in_valid && in_ready && (in_sel == 1'(c));
            pop[c]  = (count[c] != 2'd0) && out_ready[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                mem[c][0] <= '0;
                mem[c][1] <= '0;
                count[c]  <= 2'd0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem[c][wr_ptr[c]] <= in_data;
                    wr_ptr[c]         <= ~wr_ptr[c];
                end
                if (pop[c]) begin
                    rd_ptr[c] <= ~rd_ptr[c];
                end
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + 2'd1;
                    2'b01:   count[c] <= count[c] - 2'd1;
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    // Heads come straight from FIFO storage; no input-to-output path.
    assign out0_data  = mem[0][rd_ptr[0]];
    assign out1_data  = mem[1][rd_ptr[1]];
    assign out0_valid = (count[0] != 2'd0);
    assign out1_valid = (count[1] != 2'd0);

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 16'h0000;
            cnt1 <= 16'h0000;
        end else begin
            if (pop[0]) cnt0 <= cnt0 + 16'd1;
            if (pop[1]) cnt1 <= cnt1 + 16'd1;
        end
    end
`else
    assign cnt0 = 16'h0000;
    assign cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Scoreboard bench for demux_1x2_stream: per-channel expected-word queues filled on
// accept, drained and compared by a negedge monitor; handles both DEMUX_STATS_EN builds.
module tb_demux_1x2_stream;

`ifdef DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [7:0]  out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] cnt_m0 = 16'd0;
    logic [15:0] cnt_m1 = 16'd0;
    bit          last_acc = 1'b0;

    demux_1x2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model's queues are the occupancy, so readiness, valids,
    // head data and counters all follow from them.
    always @(negedge clk) begin
        logic [7:0] e;
        check("in_ready", in_ready, (in_sel ? q1.size() : q0.size()) < 2);
        check("out0_valid", out0_valid, q0.size() != 0);
        check("out1_valid", out1_valid, q1.size() != 0);
        check("cnt0", cnt0, STATS ? cnt_m0 : 16'd0);
        check("cnt1", cnt1, STATS ? cnt_m1 : 16'd0);
        if (out0_valid && out0_ready) begin
            if (q0.size() == 0) check("ch0_spurious", 1, 0);
            else begin
                e = q0.pop_front();
                check("ch0_data", out0_data, e);
                cnt_m0 = cnt_m0 + 16'd1;
            end
        end
        if (out1_valid && out1_ready) begin
            if (q1.size() == 0) check("ch1_spurious", 1, 0);
            else begin
                e = q1.pop_front();
                check("ch1_data", out1_data, e);
                cnt_m1 = cnt_m1 + 16'd1;
            end
        end
    end

    // One clock: accept is decided on the pre-edge inputs, inputs may change #1 after.
    task automatic cycle();
        bit acc;
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
        @(posedge clk);
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        cnt_m0 = 16'd0;
        cnt_m1 = 16'd0;
        in_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        in_valid = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check("drain_remaining", q0.size() + q1.size(), 0);
    endtask

    task automatic send(input logic sel, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0;
        in_sel = 1'b0;
        in_valid = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset then idle
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("rst_in_ready", in_ready, 1);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_cnt0", cnt0, 0);

        // Basic routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(1'b0, 8'hA5);
        check("route_v0", out0_valid, 1);
        check("route_d0", out0_data, 8'hA5);
        send(1'b1, 8'h3C);
        check("route_v1", out1_valid, 1);
        check("route_d1", out1_data, 8'h3C);
        in_valid = 1'b0;
        cycle();
        check("route_cnt0", cnt0, STATS ? 1 : 0);
        check("route_cnt1", cnt1, STATS ? 1 : 0);

        // Fill and stall channel 0
        out0_ready = 1'b0;
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        check("stall_not_acc", last_acc, 0);
        check("stall_in_ready", in_ready, 0);
        out0_ready = 1'b1;
        cycle();
        check("stall_no_pushthru", last_acc, 0);
        check("stall_head", out0_data, 8'h22);
        check("stall_ready_after_pop", in_ready, 1);
        cycle();
        check("stall_acc_33", last_acc, 1);
        drain(20);

        // No head-of-line blocking
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b1, 8'h01);
        send(1'b1, 8'h02);
        in_sel = 1'b0;
        in_data = 8'hF0;
        #1;
        check("hol_in_ready", in_ready, 1);
        cycle();
        check("hol_acc", last_acc, 1);
        check("hol_d0", out0_data, 8'hF0);
        check("hol_v1", out1_valid, 1);
        check("hol_d1", out1_data, 8'h01);
        drain(20);

        // Reset mid-stream with two words buffered per channel
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 8'h81);
        send(1'b0, 8'h82);
        send(1'b1, 8'h91);
        send(1'b1, 8'h92);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        cnt_m0 = 16'd0;
        cnt_m1 = 16'd0;
        #1;
        check("mrst_v0", out0_valid, 0);
        check("mrst_v1", out1_valid, 0);
        check("mrst_cnt1", cnt1, 0);
        cycle();
        rst_n = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Randomised traffic with held words while stalled
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        drain(20);

        // Counter wrap on channel 1 (a short stream when counters are absent)
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        in_sel = 1'b1;
        for (int i = 0; i < (STATS ? 65537 : 300); i++) begin
            in_data = 8'(i);
            cycle();
        end
        drain(10);
        cycle();
        check("wrap_cnt1", cnt1, STATS ? 1 : 0);
        check("wrap_cnt0", cnt0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
